cpu4_control_unit: RTL and testbench

- Sequencer and instruction decoder for the 4-bit microprocessor. It fetches 8-bit instruction words from program memory over a req/ack handshake and decodes them into the one-hot ALU operation code.
- It drives the ALU operand and accumulator inputs and writes the ALU result back into the accumulator. It also handles jumps, output transfers and halt.
- It sits between program ROM and the combinational ALU and is the producer of the ALU's operation-select interface.

---
 rtl/cpu4_pkg.sv | 42 ++++
 rtl/cpu4_decoder.sv | 34 +++
 rtl/cpu4_control_unit.sv | 132 +++++++++++++
 tb/tb_cpu4_control_unit.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu4_pkg.sv
// Shared definitions for the 4-bit CPU: one-hot ALU select codes, opcodes,
// sequencer states and the decoded-instruction record.
package cpu4_pkg;

   localparam logic [7:0] DI_AND  = 8'b1000_0000;
   localparam logic [7:0] DI_OR   = 8'b0100_0000;
   localparam logic [7:0] DI_XOR  = 8'b0010_0000;
   localparam logic [7:0] DI_SUM  = 8'b0001_0000;
   localparam logic [7:0] DI_INV  = 8'b0000_1000;
   localparam logic [7:0] DI_HOLD = 8'b0000_0100;
   localparam logic [7:0] DI_LOAD = 8'b0000_0010;

   localparam logic [3:0] OPC_NOP  = 4'h0;
   localparam logic [3:0] OPC_LDI  = 4'h1;
   localparam logic [3:0] OPC_AND  = 4'h2;
   localparam logic [3:0] OPC_OR   = 4'h3;
   localparam logic [3:0] OPC_XOR  = 4'h4;
   localparam logic [3:0] OPC_ADD  = 4'h5;
   localparam logic [3:0] OPC_INV  = 4'h6;
   localparam logic [3:0] OPC_JMP  = 4'h7;
   localparam logic [3:0] OPC_JZ   = 4'h8;
   localparam logic [3:0] OPC_OUT  = 4'h9;
   localparam logic [3:0] OPC_HALT = 4'hF;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXEC,
      OUT_WAIT,
      HALT
   } state_e;

   typedef struct packed {
      logic [7:0] di;
      logic       is_jump;
      logic       is_jz;
      logic       is_out;
      logic       is_halt;
      logic       writes_acc;
   } dec_t;

endpackage

// File: rtl/cpu4_decoder.sv
// Combinational opcode decoder: maps an opcode onto the ALU select code and
// the control flags the sequencer needs.
module cpu4_decoder
   import cpu4_pkg::*;
#(
   parameter logic [3:0] HALT_OPC = OPC_HALT
) (
   input  logic [3:0] opcode_i,
   output dec_t       dec_o
);

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      dec_o    = '0;
      dec_o.di = DI_HOLD;
      if (opcode_i == HALT_OPC) begin
         dec_o.is_halt = 1'b1;
      end else begin
         case (opcode_i)
            OPC_LDI: begin dec_o.di = DI_LOAD; dec_o.writes_acc = 1'b1; end
            OPC_AND: begin dec_o.di = DI_AND;  dec_o.writes_acc = 1'b1; end
            OPC_OR:  begin dec_o.di = DI_OR;   dec_o.writes_acc = 1'b1; end
            OPC_XOR: begin dec_o.di = DI_XOR;  dec_o.writes_acc = 1'b1; end
            OPC_ADD: begin dec_o.di = DI_SUM;  dec_o.writes_acc = 1'b1; end
            OPC_INV: begin dec_o.di = DI_INV;  dec_o.writes_acc = 1'b1; end
            OPC_JMP: dec_o.is_jump = 1'b1;
            OPC_JZ:  dec_o.is_jz   = 1'b1;
            OPC_OUT: dec_o.is_out  = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/cpu4_control_unit.sv
// Sequencer for the 4-bit CPU: fetches instruction bytes over req/ack, drives
// the external ALU, writes results back to the accumulator, handles jumps/output/halt.
module cpu4_control_unit
   import cpu4_pkg::*;
#(
   parameter int         PC_W     = 4,
   parameter logic [3:0] HALT_OPC = OPC_HALT
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   output logic            mem_req_o,
   output logic [PC_W-1:0] mem_addr_o,
   input  logic            mem_ack_i,
   input  logic [7:0]      mem_data_i,
   output logic [7:0]      di_o,
   output logic [3:0]      rd_o,
   output logic [3:0]      acc_o,
   input  logic [3:0]      op_i,
   output logic [3:0]      out_data_o,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic            zero_o,
   output logic            halted_o
);

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [3:0]      acc_q, acc_d;
   logic [7:0]      ir_q, ir_d;
   logic [7:0]      di_q, di_d;
   logic [3:0]      rd_q, rd_d;
   logic [3:0]      out_data_q, out_data_d;
   logic            mem_req_q, mem_req_d;
   logic            out_valid_q, out_valid_d;
   dec_t            dec;

   // Decodes the latched instruction; consulted in both DECODE and EXEC.
   cpu4_decoder #(.HALT_OPC(HALT_OPC)) u_decoder (
      .opcode_i (ir_q[7:4]),
      .dec_o    (dec)
   );

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      acc_d       = acc_q;
      ir_d        = ir_q;
      di_d        = di_q;
      rd_d        = rd_q;
      out_data_d  = out_data_q;
      mem_req_d   = mem_req_q;
      out_valid_d = out_valid_q;

      case (state_q)
         FETCH: begin
            mem_req_d = 1'b1;
            // An ack only counts once the request is actually visible outside.
            if (mem_req_q && mem_ack_i) begin
               ir_d      = mem_data_i;
               pc_d      = pc_q + PC_W'(1);
               mem_req_d = 1'b0;
               state_d   = DECODE;
            end
         end
         DECODE: begin
            di_d = dec.di;
            rd_d = ir_q[3:0];
            if (dec.is_halt) begin
               state_d = HALT;
            end else if (dec.is_out) begin
               out_valid_d = 1'b1;
               out_data_d  = acc_q;
               state_d     = OUT_WAIT;
            end else begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (dec.writes_acc) acc_d = op_i;
            if (dec.is_jump || (dec.is_jz && acc_q == 4'd0)) pc_d = PC_W'(ir_q[3:0]);
            di_d      = DI_HOLD;
            mem_req_d = 1'b1;
            state_d   = FETCH;
         end
         OUT_WAIT: begin
            if (out_ready_i) begin
               out_valid_d = 1'b0;
               mem_req_d   = 1'b1;
               state_d     = FETCH;
            end
         end
         HALT: ;
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= FETCH;
         pc_q        <= '0;
         acc_q       <= '0;
         ir_q        <= '0;
         di_q        <= DI_HOLD;
         rd_q        <= '0;
         out_data_q  <= '0;
         mem_req_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop updates from pre-edge values, independent of statement order.
         state_q     <= state_d;
         pc_q        <= pc_d;
         acc_q       <= acc_d;
         ir_q        <= ir_d;
         di_q        <= di_d;
         rd_q        <= rd_d;
         out_data_q  <= out_data_d;
         mem_req_q   <= mem_req_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign mem_req_o   = mem_req_q;
   assign mem_addr_o  = pc_q;
   assign di_o        = di_q;
   assign rd_o        = rd_q;
   assign acc_o       = acc_q;
   assign out_data_o  = out_data_q;
   assign out_valid_o = out_valid_q;
   assign zero_o      = (acc_q == 4'd0);
   assign halted_o    = (state_q == HALT);

endmodule

// File: tb/tb_cpu4_control_unit.sv
// Self-checking bench for cpu4_control_unit: program ROM and ALU models with
// randomised handshake timing, checked against an instruction-level interpreter.
module tb_cpu4_control_unit;

   logic       clk_i       = 1'b0;
   logic       rst_ni      = 1'b0;
   logic       mem_ack_i   = 1'b0;
   logic [7:0] mem_data_i  = 8'h00;
   logic       out_ready_i = 1'b0;
   logic [3:0] op_i;
   logic       mem_req_o;
   logic [3:0] mem_addr_o;
   logic [7:0] di_o;
   logic [3:0] rd_o, acc_o, out_data_o;
   logic       out_valid_o, zero_o, halted_o;

   int checks   = 0;
   int failures = 0;

   logic [7:0] rom [16];
   int  ack_delay = 0, rdy_delay = 0;
   bit  rand_delays = 1'b0;
   int  ack_cnt = 0, rdy_cnt = 0, last_ack_wait = 0, last_rdy_wait = 0;
   int  prev_addr = 0, prev_data = 0, prev_acc = 0;
   bit  req_wait = 1'b0, out_wait = 1'b0, out_done = 1'b0;
   int  stab_err = 0, excl_err = 0;
   int  fetch_log[$], out_log[$], acc_log[$], dirx_log[$];
   int  exp_fetch[$], exp_out[$], exp_acc[$], exp_dirx[$];
   bit  exp_halt;
   int  exp_final_acc;

   cpu4_control_unit dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .mem_req_o   (mem_req_o),
      .mem_addr_o  (mem_addr_o),
      .mem_ack_i   (mem_ack_i),
      .mem_data_i  (mem_data_i),
      .di_o        (di_o),
      .rd_o        (rd_o),
      .acc_o       (acc_o),
      .op_i        (op_i),
      .out_data_o  (out_data_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .zero_o      (zero_o),
      .halted_o    (halted_o)
   );

   always #5 clk_i = ~clk_i;

   // Combinational ALU driven by the one-hot select.
   always_comb begin
      op_i = acc_o;
      case (di_o)
         8'h80: op_i = acc_o & rd_o;
         8'h40: op_i = acc_o | rd_o;
         8'h20: op_i = acc_o ^ rd_o;
         8'h10: op_i = acc_o + rd_o;
         8'h08: op_i = ~acc_o;
         8'h02: op_i = rd_o;
         default: op_i = acc_o;
      endcase
   end

   // ROM / output-sink responder and protocol monitor, all on the falling edge.
   initial begin
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            mem_ack_i   = 1'b0;
            out_ready_i = 1'b0;
            ack_cnt  = 0; rdy_cnt  = 0; prev_acc = 0;
            req_wait = 1'b0; out_wait = 1'b0; out_done = 1'b0;
         end else begin
            if (req_wait && (mem_req_o !== 1'b1 || int'(mem_addr_o) != prev_addr)) stab_err++;
            if (out_wait && (out_valid_o !== 1'b1 || int'(out_data_o) != prev_data)) stab_err++;
            if (out_done && out_valid_o !== 1'b0) stab_err++;
            if (mem_req_o === 1'b1 && out_valid_o === 1'b1) excl_err++;
            if (int'(acc_o) != prev_acc) begin
               acc_log.push_back(int'(acc_o));
               prev_acc = int'(acc_o);
            end
            if (di_o !== 8'h04) dirx_log.push_back(int'({di_o, rd_o}));
            req_wait = 1'b0; out_wait = 1'b0; out_done = 1'b0;

            if (mem_req_o === 1'b1) begin
               if (ack_cnt >= ack_delay) begin
                  mem_ack_i  = 1'b1;
                  mem_data_i = rom[mem_addr_o];
                  fetch_log.push_back(int'(mem_addr_o));
                  last_ack_wait = ack_cnt;
                  ack_cnt = 0;
                  if (rand_delays) ack_delay = $urandom_range(0, 3);
               end else begin
                  mem_ack_i  = 1'b0;
                  ack_cnt++;
                  req_wait  = 1'b1;
                  prev_addr = int'(mem_addr_o);
               end
            end else begin
               mem_ack_i  = 1'($urandom_range(0, 1));
               mem_data_i = 8'($urandom);
            end

            if (out_valid_o === 1'b1) begin
               if (rdy_cnt >= rdy_delay) begin
                  out_ready_i = 1'b1;
                  out_log.push_back(int'(out_data_o));
                  last_rdy_wait = rdy_cnt;
                  rdy_cnt  = 0;
                  out_done = 1'b1;
                  if (rand_delays) rdy_delay = $urandom_range(0, 3);
               end else begin
                  out_ready_i = 1'b0;
                  rdy_cnt++;
                  out_wait  = 1'b1;
                  prev_data = int'(out_data_o);
               end
            end else begin
               out_ready_i = 1'($urandom_range(0, 1));
            end
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", checks, failures);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_q(input string tag, input int got[$], input int exp[$]);
      check({tag, " length"}, got.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 16; i++) rom[i] = 8'hF0;
   endtask

   // Instruction-level interpreter. Stops before executing fetch number 'limit'
   // (the bench stops the DUT at that same handshake) or after a halt.
   task automatic model_run(input int limit);
      int pc = 0, acc = 0, nacc, opc, opr;
      exp_fetch.delete(); exp_out.delete(); exp_acc.delete(); exp_dirx.delete();
      exp_halt = 1'b0;
      for (int n = 0; n < limit; n++) begin
         exp_fetch.push_back(pc);
         if (n == limit - 1) break;
         opc  = int'(rom[pc][7:4]);
         opr  = int'(rom[pc][3:0]);
         pc   = (pc + 1) % 16;
         nacc = acc;
         case (opc)
            1:  begin nacc = opr;              exp_dirx.push_back('h02 * 16 + opr); end
            2:  begin nacc = acc & opr;        exp_dirx.push_back('h80 * 16 + opr); end
            3:  begin nacc = acc | opr;        exp_dirx.push_back('h40 * 16 + opr); end
            4:  begin nacc = acc ^ opr;        exp_dirx.push_back('h20 * 16 + opr); end
            5:  begin nacc = (acc + opr) % 16; exp_dirx.push_back('h10 * 16 + opr); end
            6:  begin nacc = 15 - acc;         exp_dirx.push_back('h08 * 16 + opr); end
            7:  pc = opr;
            8:  if (acc == 0) pc = opr;
            9:  exp_out.push_back(acc);
            15: exp_halt = 1'b1;
            default: ;
         endcase
         if (nacc != acc) exp_acc.push_back(nacc);
         acc = nacc;
         if (exp_halt) break;
      end
      exp_final_acc = acc;
   endtask

   task automatic apply_reset();
      rst_ni = 1'b0;
      repeat (2) @(negedge clk_i);
      fetch_log.delete(); out_log.delete(); acc_log.delete(); dirx_log.delete();
      stab_err = 0; excl_err = 0;
      #1 rst_ni = 1'b1;
   endtask

   task automatic run_program(input string tag, input int limit, input int ackd,
                              input int rdyd, input bit rnd);
      bit done = 1'b0;
      ack_delay = ackd; rdy_delay = rdyd; rand_delays = rnd;
      model_run(limit);
      apply_reset();
      for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
         @(negedge clk_i); #1;
         if (halted_o === 1'b1 || fetch_log.size() >= limit) done = 1'b1;
      end
      check({tag, " finished in budget"}, done, 1);
      check_q({tag, " fetch addr"}, fetch_log, exp_fetch);
      check_q({tag, " out data"}, out_log, exp_out);
      check_q({tag, " acc trace"}, acc_log, exp_acc);
      check_q({tag, " alu select"}, dirx_log, exp_dirx);
      check({tag, " halted"}, halted_o, exp_halt);
      check({tag, " acc"}, acc_o, exp_final_acc);
      check({tag, " zero"}, zero_o, exp_final_acc == 0);
      check({tag, " handshake stability"}, stab_err, 0);
      check({tag, " req/valid exclusive"}, excl_err, 0);
      if (exp_halt) begin
         repeat (4) begin
            @(negedge clk_i); #1;
            check({tag, " req low in halt"}, mem_req_o, 1'b0);
            check({tag, " acc frozen"}, acc_o, exp_final_acc);
         end
      end
   endtask

   task automatic restart_from_zero(input string tag);
      ack_delay = 0; rdy_delay = 0;
      repeat (2) @(negedge clk_i);
      fetch_log.delete();
      #1 rst_ni = 1'b1;
      for (int cyc = 0; cyc < 20 && fetch_log.size() == 0; cyc++) @(negedge clk_i);
      #1;
      check({tag, " restart fetched"}, fetch_log.size() > 0, 1'b1);
      check({tag, " restart addr"}, fetch_log.size() > 0 ? fetch_log[0] : -1, 0);
   endtask

   initial begin
      clear_rom();

      // Reset values and the first request edge.
      rst_ni = 1'b0;
      repeat (2) @(negedge clk_i); #1;
      check("reset mem_req", mem_req_o, 1'b0);
      check("reset out_valid", out_valid_o, 1'b0);
      check("reset out_data", out_data_o, 4'h0);
      check("reset halted", halted_o, 1'b0);
      check("reset acc", acc_o, 4'h0);
      check("reset addr", mem_addr_o, 4'h0);
      check("reset di", di_o, 8'h04);
      check("reset rd", rd_o, 4'h0);
      check("reset zero", zero_o, 1'b1);
      rst_ni = 1'b1;
      @(negedge clk_i); #1;
      check("first edge mem_req", mem_req_o, 1'b1);

      // LDI 5, ADD 3, OUT, HALT.
      clear_rom();
      rom[0] = 8'h15; rom[1] = 8'h53; rom[2] = 8'h90; rom[3] = 8'hF0;
      run_program("prog_add_out", 32, 0, 0, 1'b0);

      // ADD wraps to zero, JZ 0 loops back.
      clear_rom();
      rom[0] = 8'h1F; rom[1] = 8'h51; rom[2] = 8'h80; rom[3] = 8'h1A; rom[4] = 8'hF0;
      run_program("prog_wrap_jz", 6, 0, 0, 1'b0);

      // AND/INV then output held while the sink stalls 5 cycles.
      clear_rom();
      rom[0] = 8'h1C; rom[1] = 8'h2A; rom[2] = 8'h63; rom[3] = 8'h90;
      run_program("prog_stall_out", 32, 0, 5, 1'b0);
      check("stall out wait cycles", last_rdy_wait, 5);

      // Slow memory and pc wrap from 15 to 0.
      clear_rom();
      rom[0] = 8'h7E; rom[14] = 8'h00; rom[15] = 8'h00;
      run_program("prog_pc_wrap", 5, 3, 0, 1'b0);
      check("slow fetch wait cycles", last_ack_wait, 3);

      // Undefined opcode behaves as NOP.
      clear_rom();
      rom[0] = 8'h14; rom[1] = 8'hB7; rom[2] = 8'h90; rom[3] = 8'hF0;
      run_program("prog_undef", 32, 0, 0, 1'b0);

      // Asynchronous reset while a fetch is pending.
      clear_rom();
      rom[0] = 8'h15; rom[1] = 8'h00; rom[2] = 8'h00;
      ack_delay = 0; rdy_delay = 0; rand_delays = 1'b0;
      apply_reset();
      for (int cyc = 0; cyc < 50 && fetch_log.size() < 2; cyc++) @(negedge clk_i);
      ack_delay = 1000;
      repeat (4) @(negedge clk_i); #1;
      check("mid-fetch req before reset", mem_req_o, 1'b1);
      check("mid-fetch addr before reset", mem_addr_o, 4'h2);
      check("mid-fetch acc before reset", acc_o, 4'h5);
      #2 rst_ni = 1'b0;
      #1;
      check("mid-fetch reset req", mem_req_o, 1'b0);
      check("mid-fetch reset addr", mem_addr_o, 4'h0);
      check("mid-fetch reset acc", acc_o, 4'h0);
      check("mid-fetch reset di", di_o, 8'h04);
      check("mid-fetch reset valid", out_valid_o, 1'b0);
      restart_from_zero("mid-fetch");

      // Asynchronous reset while an output transfer is stalled.
      clear_rom();
      rom[0] = 8'h13; rom[1] = 8'h90;
      ack_delay = 0; rdy_delay = 1000;
      apply_reset();
      for (int cyc = 0; cyc < 50 && out_valid_o !== 1'b1; cyc++) @(negedge clk_i);
      #1;
      check("mid-out valid before reset", out_valid_o, 1'b1);
      check("mid-out data before reset", out_data_o, 4'h3);
      @(negedge clk_i);
      #3 rst_ni = 1'b0;
      #1;
      check("mid-out reset valid", out_valid_o, 1'b0);
      check("mid-out reset data", out_data_o, 4'h0);
      check("mid-out reset acc", acc_o, 4'h0);
      check("mid-out reset req", mem_req_o, 1'b0);
      check("mid-out reset addr", mem_addr_o, 4'h0);
      check("mid-out reset di", di_o, 8'h04);
      restart_from_zero("mid-out");

      // Random programs with random handshake timing.
      for (int r = 0; r < 10; r++) begin
         for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
         run_program($sformatf("rand%0d", r), 24, $urandom_range(0, 3),
                     $urandom_range(0, 3), 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
